// File: rtl/fp16_accumulator.sv
// Sequential fp16 group accumulator: sums a stream of products delimited by in_last
// using a multi-cycle align/add/normalize/round datapath with round-to-nearest-even.
//
// state | meaning
// IDLE  | waiting for a product (in_ready high)
// ALIGN | unpack, detect specials, align smaller operand
// ADD   | magnitude add/subtract
// NORM  | normalize (carry right-shift or leading-zero left-shift)
// ROUND | round, write acc, decide DONE vs IDLE
// DONE  | group sum presented until out_ready
module fp16_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state, state_n;

  logic [15:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic [15:0]      term;
  logic             last_q;
  logic             spec;
  logic [15:0]      spec_val;
  logic             zero_sign;
  logic             sign_r;
  logic             sub_r;
  logic [13:0]      big_m;
  logic [13:0]      small_m;
  logic [5:0]       exp_r;
  logic [14:0]      sum_r;
  logic [13:0]      mant_q;

  // align-stage combinational signals
  logic        a_nan, a_inf, t_nan, t_inf, a_big;
  logic [15:0] l_v, s_v;
  logic [4:0]  l_e, s_e, diff;
  logic [10:0] l_m, s_m;
  logic [13:0] s_ext, s_tmp, s_sh;
  logic        s_lost;
  logic        al_spec;
  logic [15:0] al_val;

  // normalize-stage combinational signals
  logic [3:0]  lz;
  logic [5:0]  emax, shamt, n_e;
  logic [13:0] n_m;

  // round-stage combinational signals
  logic [10:0] r_mant, r_mf;
  logic        r_up;
  logic [11:0] r_sum;
  logic [5:0]  r_ef;
  logic [15:0] r_val, r_final;

  assign in_ready  = (state == S_IDLE) & ~rst;
  assign out_valid = (state == S_DONE);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (in_valid) state_n = S_ALIGN;
      S_ALIGN: state_n = S_ADD;
      S_ADD:   state_n = S_NORM;
      S_NORM:  state_n = S_ROUND;
      S_ROUND: state_n = last_q ? S_DONE : S_IDLE;
      S_DONE:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    a_nan  = (acc[14:10] == 5'h1F) && (acc[9:0] != 10'd0);
    a_inf  = (acc[14:10] == 5'h1F) && (acc[9:0] == 10'd0);
    t_nan  = (term[14:10] == 5'h1F) && (term[9:0] != 10'd0);
    t_inf  = (term[14:10] == 5'h1F) && (term[9:0] == 10'd0);
    a_big  = acc[14:0] >= term[14:0];
    l_v    = a_big ? acc : term;
    s_v    = a_big ? term : acc;
    l_e    = (l_v[14:10] == 5'd0) ? 5'd1 : l_v[14:10];
    s_e    = (s_v[14:10] == 5'd0) ? 5'd1 : s_v[14:10];
    l_m    = {|l_v[14:10], l_v[9:0]};
    s_m    = {|s_v[14:10], s_v[9:0]};
    diff   = l_e - s_e;
    s_ext  = {s_m, 3'b000};
    s_tmp  = s_ext >> diff;
    s_lost = |(s_ext & ~(14'h3FFF << diff));
    if (diff >= 5'd14) s_sh = {13'd0, |s_m};
    else               s_sh = {s_tmp[13:1], s_tmp[0] | s_lost};

    al_spec = 1'b1;
    al_val  = 16'h0000;
    if (first)               al_val = t_nan ? 16'h7E00 : term;
    else if (a_nan || t_nan) al_val = 16'h7E00;
    else if (a_inf && t_inf) al_val = (acc[15] == term[15]) ? acc : 16'h7E00;
    else if (a_inf)          al_val = acc;
    else if (t_inf)          al_val = term;
    else                     al_spec = 1'b0;
  end

  always_comb begin
    lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (sum_r[i]) lz = 4'(13 - i);
    end
    emax  = exp_r - 6'd1;
    shamt = ({2'b00, lz} > emax) ? emax : {2'b00, lz};
    if (sum_r[14]) begin
      n_m = {sum_r[14:2], sum_r[1] | sum_r[0]};
      n_e = exp_r + 6'd1;
    end else begin
      n_m = sum_r[13:0] << shamt;
      n_e = exp_r - shamt;
    end
  end

  always_comb begin
    r_mant = mant_q[13:3];
    r_up   = mant_q[2] & ((|mant_q[1:0]) | r_mant[0]);
    r_sum  = {1'b0, r_mant} + {11'd0, r_up};
    if (r_sum[11]) begin
      r_mf = r_sum[11:1];
      r_ef = exp_r + 6'd1;
    end else begin
      r_mf = r_sum[10:0];
      r_ef = exp_r;
    end
    // mantissa without hidden bit can only occur at effective exp 1 (subnormal)
    if (r_ef >= 6'd31) r_val = {sign_r, 5'h1F, 10'd0};
    else               r_val = {sign_r, r_mf[10] ? r_ef[4:0] : 5'd0, r_mf[9:0]};
    r_final = spec ? spec_val : r_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= 16'h0000;
      cnt       <= '0;
      first     <= 1'b1;
      out_data  <= 16'h0000;
      out_count <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            term   <= in_data;
            last_q <= in_last;
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end
        S_ALIGN: begin
          spec      <= al_spec;
          spec_val  <= al_val;
          zero_sign <= acc[15] & term[15];
          sign_r    <= l_v[15];
          sub_r     <= acc[15] ^ term[15];
          big_m     <= {l_m, 3'b000};
          small_m   <= s_sh;
          exp_r     <= {1'b0, l_e};
        end
        S_ADD: begin
          sum_r <= sub_r ? ({1'b0, big_m} - {1'b0, small_m})
                         : ({1'b0, big_m} + {1'b0, small_m});
        end
        S_NORM: begin
          if (!spec && sum_r == 15'd0) begin
            spec     <= 1'b1;
            spec_val <= {zero_sign, 15'd0};
          end
          mant_q <= n_m;
          exp_r  <= n_e;
        end
        S_ROUND: begin
          acc   <= r_final;
          first <= 1'b0;
          if (last_q) begin
            out_data  <= r_final;
            out_count <= cnt;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            cnt   <= '0;
            first <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Self-checking bench for fp16_accumulator: directed spec vectors plus random groups
// compared against a real-arithmetic fp16 reference model.
module tb_fp16_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_count;

  fp16_accumulator #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_acc;
  logic        m_first;
  int          m_cnt;
  logic [15:0] grp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real mag;
    int  e = int'(h[14:10]);
    int  f = int'(h[9:0]);
    if (e == 0) mag = real'(f) * pow2(-24);
    else        mag = real'(1024 + f) * pow2(e - 25);
    return h[15] ? -mag : mag;
  endfunction

  // round an exactly-representable real to fp16, nearest-even
  function automatic logic [15:0] r2h(input real x);
    logic        s = (x < 0.0);
    real         a = s ? -x : x;
    int          e = 15;
    real         q, n, rem;
    int          fl;
    logic [4:0]  ef;
    logic [10:0] fm;
    if (a >= 65520.0) return {s, 5'h1F, 10'd0};
    while (e > -14 && a < pow2(e)) e--;
    q   = pow2(e - 10);
    n   = a / q;
    fl  = $rtoi(n);
    rem = n - real'(fl);
    if (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1)) fl++;
    if (fl >= 2048) begin fl = 1024; e++; end
    if (e > 15) return {s, 5'h1F, 10'd0};
    fm = 11'(fl);
    ef = (fl < 1024) ? 5'd0 : 5'(e + 15);
    return {s, ef, fm[9:0]};
  endfunction

  function automatic logic is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    real sum;
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (is_inf(a) && is_inf(b)) return (a[15] == b[15]) ? a : 16'h7E00;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    sum = h2r(a) + h2r(b);
    if (sum == 0.0) return {a[15] & b[15], 15'd0};
    return r2h(sum);
  endfunction

  task automatic model_accept(input logic [15:0] t);
    if (m_first) m_acc = is_nan(t) ? 16'h7E00 : t;
    else         m_acc = model_add(m_acc, t);
    m_first = 1'b0;
    m_cnt++;
  endtask

  task automatic model_reset();
    m_acc = 16'h0000; m_first = 1'b1; m_cnt = 0;
  endtask

  task automatic send(input logic [15:0] t, input logic last, output int acc_cyc);
    int waited = 0;
    in_valid = 1'b1; in_data = t; in_last = last;
    while (!in_ready && waited < 40) begin
      @(posedge clk); #1; waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      acc_cyc = cyc;
    end else begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      model_accept(t);
    end
    in_valid = 1'b0;
  endtask

  // send grp as one group (last on final term) and check the result handshake
  task automatic run_group(input int stall, input logic use_c, input logic [15:0] exp_c,
                           input logic [31:0] exp_cnt_c);
    int prev = 0, cur = 0, lat = 0, exp_cnt;
    logic [15:0] hold_d;
    logic [7:0]  hold_c;
    for (int i = 0; i < grp.size(); i++) begin
      send(grp[i], (i == grp.size() - 1), cur);
      if (i > 0) chk("accept_interval", 32'(cur - prev), 32'd5);
      prev = cur;
    end
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("out_valid", 32'(out_valid), 32'd1);
    exp_cnt = (m_cnt > 255) ? 255 : m_cnt;
    chk("out_data_model", 32'(out_data), 32'(m_acc));
    chk("out_count_model", 32'(out_count), 32'(exp_cnt));
    if (use_c) begin
      chk("out_data_const", 32'(out_data), 32'(exp_c));
      chk("out_count_const", 32'(out_count), exp_cnt_c);
    end
    hold_d = out_data; hold_c = out_count;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(hold_d));
      chk("stall_count", 32'(out_count), 32'(hold_c));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("hold_data", 32'(out_data), 32'(hold_d));
    m_first = 1'b1; m_cnt = 0;
  endtask

  task automatic pair(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
    grp = {a, b};
    run_group(0, 1'b1, r, 32'd2);
  endtask

  function automatic logic [15:0] rand_fp16();
    logic        s = 1'($urandom_range(0, 1));
    logic [9:0]  f = 10'($urandom_range(0, 1023));
    int          c = $urandom_range(0, 19);
    case (c)
      0:       return {s, 5'h1F, 10'($urandom_range(1, 1023))};
      1:       return {s, 5'h1F, 10'd0};
      2:       return {s, 15'd0};
      3:       return {s, 5'd0, f};
      4, 5, 6, 7, 8, 9, 10, 11: return {s, 5'($urandom_range(12, 18)), f};
      default: return {s, 5'($urandom_range(1, 30)), f};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, seen;
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // basic sum with a 3-cycle output stall
    grp = {16'h3C00, 16'h4000, 16'h4200};
    run_group(3, 1'b1, 16'h4600, 32'd3);

    pair(16'h3C00, 16'hBC00, 16'h0000);
    pair(16'h8000, 16'h8000, 16'h8000);
    grp = {16'h8000};
    run_group(0, 1'b1, 16'h8000, 32'd1);
    pair(16'h7BFF, 16'h7BFF, 16'h7C00);
    pair(16'h7C00, 16'hFC00, 16'h7E00);
    pair(16'h7C01, 16'h3C00, 16'h7E00);
    pair(16'hFC00, 16'h3C00, 16'hFC00);
    pair(16'h3C00, 16'h1000, 16'h3C00);
    pair(16'h3C01, 16'h1000, 16'h3C02);
    pair(16'h0200, 16'h0200, 16'h0400);
    pair(16'h0401, 16'h8400, 16'h0001);
    grp = {16'h7E00, 16'h3C00, 16'hFC00};
    run_group(1, 1'b1, 16'h7E00, 32'd3);

    // counter saturation
    grp.delete();
    for (int i = 0; i < 300; i++) grp.push_back(16'h0000);
    run_group(0, 1'b1, 16'h0000, 32'd255);

    // reset while the last term is in NORM
    send(16'h3C00, 1'b0, c0);
    send(16'h4000, 1'b1, c0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
    grp = {16'h4000};
    run_group(0, 1'b1, 16'h4000, 32'd1);

    // random groups against the reference model
    for (int g = 0; g < 40; g++) begin
      int n = $urandom_range(1, 4);
      grp.delete();
      for (int k = 0; k < n; k++) grp.push_back(rand_fp16());
      run_group($urandom_range(0, 2), 1'b0, 16'h0000, 32'd0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
